// File: rtl/writeback_arbiter.sv
// Merges pipeline MEM/WB results with buffered mul/div results onto one register-file write port.
// Optional macro WB_BYPASS_EN adds forwarding outputs from the registered write port.
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        md_issue_valid,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        stall,
  output logic        wb_hold,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_reg_addr,
  output logic [31:0] rf_reg_write_data
`ifdef WB_BYPASS_EN
  ,
  output logic        byp1_hit,
  output logic [31:0] byp1_data,
  output logic        byp2_hit,
  output logic [31:0] byp2_data
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       r_mem_rd   [FIFO_DEPTH];
  logic [31:0]      r_mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_busy;
  logic [STV_W-1:0] r_starve;
  logic             r_wr_en_p1;
  logic [4:0]       r_wr_addr_p1;
  logic [31:0]      r_wr_data_p1;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [4:0]       w_head_rd;
  logic [31:0]      w_head_data;
  logic [31:0]      w_busy_nxt;

  // Readiness and pop eligibility use only registered occupancy, so an entry
  // pushed this cycle can never be popped in the same cycle.
  assign w_empty     = (r_count == '0);
  assign md_ready    = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push      = md_valid & md_ready;
  assign w_pop       = ~wb_valid & ~w_empty;
  assign w_head_rd   = r_mem_rd[r_rd_ptr];
  assign w_head_data = r_mem_data[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= md_rd;
      r_mem_data[r_wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new issue to the same rd as the popped result keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head_rd] = 1'b0;
    if (md_issue_valid && md_issue_rd != 5'd0) w_busy_nxt[md_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign stall = ~reset & (((rs1_addr != 5'd0) & r_busy[rs1_addr]) |
                           ((rs2_addr != 5'd0) & r_busy[rs2_addr]));

  always_ff @(posedge clk) begin
    if (reset)                                  r_starve <= '0;
    else if (r_starve == STV_W'(STARVE_LIMIT))  r_starve <= '0;
    else if (!w_empty && wb_valid)              r_starve <= r_starve + STV_W'(1);
    else                                        r_starve <= '0;
  end

  assign wb_hold = ~reset & (r_starve == STV_W'(STARVE_LIMIT));

  // Stage p1: registered register-file write port; pipeline result wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en_p1   <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else if (wb_valid) begin
      r_wr_en_p1   <= (wb_rd != 5'd0);
      r_wr_addr_p1 <= wb_rd;
      r_wr_data_p1 <= wb_data;
    end else if (w_pop) begin
      r_wr_en_p1   <= (w_head_rd != 5'd0);
      r_wr_addr_p1 <= w_head_rd;
      r_wr_data_p1 <= w_head_data;
    end else begin
      r_wr_en_p1   <= 1'b0;
    end
  end

  assign rf_write_enable   = r_wr_en_p1;
  assign rf_write_reg_addr = r_wr_addr_p1;
  assign rf_reg_write_data = r_wr_data_p1;

`ifdef WB_BYPASS_EN
  assign byp1_hit  = r_wr_en_p1 & (rs1_addr != 5'd0) & (r_wr_addr_p1 == rs1_addr);
  assign byp2_hit  = r_wr_en_p1 & (rs2_addr != 5'd0) & (r_wr_addr_p1 == rs2_addr);
  assign byp1_data = byp1_hit ? r_wr_data_p1 : 32'd0;
  assign byp2_data = byp2_hit ? r_wr_data_p1 : 32'd0;
`endif

endmodule
